// File: rtl/cmd_frame_decoder.sv
// ---------------------------------------------------------------------------
// cmd_frame_decoder
//   Decodes byte-serial command frames into register-file and ALU controls.
//   Frames (opcode first, one byte per accepted rx_valid):
//     AA addr data  -> rf_wr_en pulse  (rf_addr, rf_wr_data latched)
//     BB addr       -> rf_rd_en pulse  (rf_addr latched)
//     CC a b fun    -> alu_en pulse    (alu_op_a, alu_op_b, alu_fun latched)
//     DD fun        -> alu_en pulse    (reuses held operands)
//   Any other opcode pulses frame_err and stays idle.
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   asynchronous reset, active low
//   rx_data    in   received byte, valid when rx_valid is high
//   rx_valid   in   one-cycle byte-accept pulse
//   rf_wr_en   out  register-file write strobe (1 cycle)
//   rf_rd_en   out  register-file read strobe (1 cycle)
//   rf_addr    out  register-file address (held)
//   rf_wr_data out  register-file write data (held)
//   alu_en     out  ALU start strobe (1 cycle)
//   alu_fun    out  ALU function code (held)
//   alu_op_a/b out  ALU operands (held)
//   busy       out  high while a frame is in progress
//   frame_err  out  one-cycle error pulse
//
// Optional feature: define CMD_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYCLES consecutive idle cycles while busy.
// ---------------------------------------------------------------------------
module cmd_frame_decoder #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic                  alu_en,
    output logic [3:0]            alu_fun,
    output logic [DATA_WIDTH-1:0] alu_op_a,
    output logic [DATA_WIDTH-1:0] alu_op_b,
    output logic                  busy,
    output logic                  frame_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_OP_A, S_OP_B, S_ALU_FUN
    } state_t;

    localparam logic [DATA_WIDTH-1:0] OPC_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OPC_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OPC_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OPC_FUN = DATA_WIDTH'(8'hDD);

    state_t                r_state;
    logic                  r_wr_en, r_rd_en, r_alu_en, r_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wr_data, r_op_a, r_op_b;
    logic [3:0]            r_fun;

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo_cnt;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_alu_en  <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_fun     <= '0;
`ifdef CMD_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
        end else begin
            // Strobes are single-cycle: default low, set only on a frame's final byte.
            r_wr_en  <= 1'b0;
            r_rd_en  <= 1'b0;
            r_alu_en <= 1'b0;
            r_err    <= 1'b0;
            if (rx_valid) begin
`ifdef CMD_TIMEOUT_EN
                r_tmo_cnt <= '0;
`endif
                case (r_state)
                    S_IDLE: begin
                        if      (rx_data == OPC_WR)  r_state <= S_WR_ADDR;
                        else if (rx_data == OPC_RD)  r_state <= S_RD_ADDR;
                        else if (rx_data == OPC_ALU) r_state <= S_OP_A;
                        else if (rx_data == OPC_FUN) r_state <= S_ALU_FUN;
                        else                         r_err   <= 1'b1;
                    end
                    S_WR_ADDR: begin
                        r_addr  <= rx_data[ADDR_WIDTH-1:0];
                        r_state <= S_WR_DATA;
                    end
                    S_WR_DATA: begin
                        r_wr_data <= rx_data;
                        r_wr_en   <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                    S_RD_ADDR: begin
                        r_addr  <= rx_data[ADDR_WIDTH-1:0];
                        r_rd_en <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    S_OP_A: begin
                        r_op_a  <= rx_data;
                        r_state <= S_OP_B;
                    end
                    S_OP_B: begin
                        r_op_b  <= rx_data;
                        r_state <= S_ALU_FUN;
                    end
                    S_ALU_FUN: begin
                        r_fun    <= rx_data[3:0];
                        r_alu_en <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
`ifdef CMD_TIMEOUT_EN
            else if (r_state == S_IDLE) begin
                r_tmo_cnt <= '0;
            end else if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                // This idle cycle is the TIMEOUT_CYCLES-th one: abort the frame.
                r_tmo_cnt <= '0;
                r_state   <= S_IDLE;
                r_err     <= 1'b1;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
`endif
        end
    end

    assign rf_wr_en   = r_wr_en;
    assign rf_rd_en   = r_rd_en;
    assign rf_addr    = r_addr;
    assign rf_wr_data = r_wr_data;
    assign alu_en     = r_alu_en;
    assign alu_fun    = r_fun;
    assign alu_op_a   = r_op_a;
    assign alu_op_b   = r_op_b;
    assign busy       = (r_state != S_IDLE);
    assign frame_err  = r_err;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_cmd_frame_decoder
//   Directed frames drive the decoder; each frame's expected output event
//   (kind, held values, cycle) is queued by the driver and checked by an
//   independent negedge monitor.
// ---------------------------------------------------------------------------
module tb_cmd_frame_decoder;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rf_wr_en, rf_rd_en, alu_en, busy, frame_err;
    logic [3:0] rf_addr, alu_fun;
    logic [7:0] rf_wr_data, alu_op_a, alu_op_b;

    cmd_frame_decoder #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
        .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
        .rf_wr_data(rf_wr_data), .alu_en(alu_en), .alu_fun(alu_fun),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .busy(busy),
        .frame_err(frame_err)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // kind bits: {wr, rd, alu, err}
    localparam logic [3:0] K_WR = 4'b1000, K_RD = 4'b0100, K_ALU = 4'b0010, K_ERR = 4'b0001;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  kind;
        logic [3:0]  addr;
        logic [7:0]  wd, a, b;
        logic [3:0]  fun;
    } ev_t;

    ev_t q[$];
    int  tests = 0;
    int  fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one byte; it is sampled at the next rising edge. Returns #1 after it.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Queue an event expected dly cycles after the last sampled byte.
    task automatic expect_ev(input logic [3:0] kind, input logic [3:0] addr,
                             input logic [7:0] wd, input logic [7:0] a,
                             input logic [7:0] b, input logic [3:0] fun,
                             input int dly);
        ev_t e;
        e.cyc = cyc + dly; e.kind = kind; e.addr = addr;
        e.wd = wd; e.a = a; e.b = b; e.fun = fun;
        q.push_back(e);
    endtask

    // Monitor: any strobe or error must match the head of the queue in that cycle.
    always @(negedge CLK) begin
        logic [3:0] k;
        k = {rf_wr_en, rf_rd_en, alu_en, frame_err};
        if (RST) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("missing_event", 32'(0), 32'(q[0].kind));
                void'(q.pop_front());
            end
            if (k != 4'b0000) begin
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    ev_t e;
                    e = q.pop_front();
                    chk("ev_kind",  32'(k),          32'(e.kind));
                    chk("ev_onehot", 32'($countones(k)), 32'(1));
                    chk("ev_busy",  32'(busy),       32'(0));
                    chk("ev_addr",  32'(rf_addr),    32'(e.addr));
                    chk("ev_wdata", 32'(rf_wr_data), 32'(e.wd));
                    chk("ev_op_a",  32'(alu_op_a),   32'(e.a));
                    chk("ev_op_b",  32'(alu_op_b),   32'(e.b));
                    chk("ev_fun",   32'(alu_fun),    32'(e.fun));
                end else begin
                    chk("unexpected_event", 32'(k), 32'(0));
                end
            end else if (q.size() > 0 && q[0].cyc == cyc) begin
                chk("missing_event", 32'(0), 32'(q[0].kind));
                void'(q.pop_front());
            end
        end
    end

    task automatic chk_all_zero(input string name);
        chk({name, "_strobes"}, 32'({rf_wr_en, rf_rd_en, alu_en, frame_err, busy}), 32'(0));
        chk({name, "_held"}, {rf_addr, rf_wr_data, alu_op_a, alu_op_b, alu_fun}, 32'(0));
    endtask

    initial begin
        #2;
        chk_all_zero("reset_state");
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1;
        idle(2);

        // Write frame
        send(8'hAA);
        chk("busy_mid_frame", 32'(busy), 32'(1));
        send(8'h05);
        send(8'h3C);
        expect_ev(K_WR, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 0);
        idle(2);

        // Read frame
        send(8'hBB); send(8'h0F);
        expect_ev(K_RD, 4'hF, 8'h3C, 8'h00, 8'h00, 4'h0, 0);
        idle(2);

        // Full ALU frame back-to-back with a DD reuse frame
        send(8'hCC); send(8'h12); send(8'h34); send(8'hF2);
        expect_ev(K_ALU, 4'hF, 8'h3C, 8'h12, 8'h34, 4'h2, 0);
        send(8'hDD); send(8'h01);
        expect_ev(K_ALU, 4'hF, 8'h3C, 8'h12, 8'h34, 4'h1, 0);
        idle(2);

        // Invalid opcode
        send(8'h55);
        expect_ev(K_ERR, 4'hF, 8'h3C, 8'h12, 8'h34, 4'h1, 0);
        idle(1);
        chk("busy_after_err", 32'(busy), 32'(0));

        // rx_data toggling without rx_valid is ignored
        rx_data = 8'hAA; idle(1);
        rx_data = 8'hCC; idle(2);
        chk("ignore_no_valid", 32'(busy), 32'(0));

        // Reset mid-frame discards it; first byte afterwards is an opcode
        send(8'hAA); send(8'h07);
        RST = 1'b0;
        #1;
        chk_all_zero("async_reset");
        idle(2);
        RST = 1'b1;
        idle(1);
        send(8'h3C);
        expect_ev(K_ERR, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 0);
        idle(2);

        // DD after reset uses zeroed operands
        send(8'hDD); send(8'h03);
        expect_ev(K_ALU, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3, 0);

        // Write then read, fully back-to-back
        send(8'hAA); send(8'h0A); send(8'h99);
        expect_ev(K_WR, 4'hA, 8'h99, 8'h00, 8'h00, 4'h3, 0);
        send(8'hBB); send(8'h02);
        expect_ev(K_RD, 4'h2, 8'h99, 8'h00, 8'h00, 4'h3, 0);
        idle(3);

`ifdef CMD_TIMEOUT_EN
        // Silence after CC aborts the frame 16 cycles later
        send(8'hCC);
        expect_ev(K_ERR, 4'h2, 8'h99, 8'h00, 8'h00, 4'h3, 16);
        idle(20);
        chk("busy_after_timeout", 32'(busy), 32'(0));

        // Byte on the expiry cycle is accepted; frame continues in OP_B
        send(8'hCC);
        idle(15);
        send(8'h44);
        chk("busy_at_expiry", 32'(busy), 32'(1));
        send(8'h55); send(8'h00);
        expect_ev(K_ALU, 4'h2, 8'h99, 8'h44, 8'h55, 4'h0, 0);
        idle(3);
`endif

        idle(5);
        chk("queue_drained", 32'(q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global bound so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
